iecdrv_mem_arbiter: RTL
=======================

Name: iecdrv_mem_arbiter

Overview:
Shares one port of the drive's dual-port RAM between two requesters. Requester 0 is the drive CPU and has priority. Requester 1 is the bulk track/image loader. The block muxes address, data and write-enable onto the RAM port, tracks the RAM's two-cycle read latency and routes read data back to the requester that issued the read. A wait counter guarantees requester 1 is not starved.

Parameters:
- DATAWIDTH, 8, RAM word width.
- ADDRWIDTH, 11, RAM address width.
- MAX_WAIT, 4, maximum consecutive cycles requester 1 can be denied while requesting (≥1).

Ports:
- clk  in  1  sole clock; the RAM port clock is the same clk.
- reset_n  in  1  asynchronous, active-low reset.
- r0_req  in  1  CPU access request, held until granted.
- r0_we  in  1  1 = write, 0 = read.
- r0_addr  in  ADDRWIDTH  CPU address.
- r0_wdata  in  DATAWIDTH  CPU write data.
- r0_gnt  out  1  combinational grant; the access is accepted in this cycle.
- r0_rvalid  out  1  read data valid pulse.
- r0_rdata  out  DATAWIDTH  read data.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as r0_*, for the loader.
- mem_addr  out  ADDRWIDTH  to RAM port address.
- mem_data  out  DATAWIDTH  to RAM port write data.
- mem_wren  out  1  to RAM port write enable.
- mem_q  in  DATAWIDTH  RAM port read data.

Behaviour:
- Grant rule, evaluated each cycle:
  - r1 wins if r1_req and (!r0_req or wait_cnt == MAX_WAIT).
  - Otherwise r0 wins if r0_req.
  - At most one gnt is high in any cycle.
- Memory port drive:
  - mem_addr/mem_data follow the granted requester.
  - mem_addr/mem_data hold their last value when idle.
  - mem_wren = granted requester's we, and 0 when idle.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - Increments when r1_req && !r1_gnt, saturating at MAX_WAIT.
  - Clears to 0 on r1_gnt or when r1_req is low.
- Read latency:
  - A read granted in cycle T gives rN_rvalid=1 in cycle T+2.
  - rN_rdata = mem_q in that same cycle (RAM registers the address, then q).
- In-flight tracking: 2-stage shift register of {valid, id}.
  - Stage 0 is loaded with {gnt & !we, winner id}.
  - Back-to-back reads from either requester are supported at full rate, one per cycle.
- Writes: no rvalid. A write in T followed by a read of the same address in T+1 returns the new data; the RAM write-through covers this.
- rN_rdata is registered.
  - Holds its last value when rvalid=0.
  - Updates only for its own id.
- Reset values: wait_cnt=0, pipeline valid bits=0, rN_rvalid=0, rN_rdata=0, mem_addr=0, mem_data=0, mem_wren=0.
- Reset mid-operation: in-flight reads are dropped. No rvalid is asserted in the two cycles after reset_n deasserts.
- r0 request with no competition: r0 is granted the same cycle.
- Simultaneous requests with wait_cnt < MAX_WAIT: r0 wins.
- Simultaneous requests with wait_cnt == MAX_WAIT: r1 wins, then the counter clears.

Optional Feature:
IECDRV_ARB_STATS_EN
- With it: adds outputs r0_count and r1_count, each 16 bits, plus input stats_clr.
  - Each counter increments on its requester's grant and saturates at 0xFFFF.
  - stats_clr clears both counters synchronously; clear wins over increment in the same cycle.
  - reset_n clears both counters.
- Without it: these ports and registers do not exist, and arbitration is identical.

Decomposition:
- Package iecdrv_arb_pkg:
  - typedef req_id_t (1 bit, ID_CPU=0, ID_LOADER=1).
  - typedef pipe_stage_t {valid, id}.
  - Constant MEM_RD_LATENCY=2.
- One natural sub-module: iecdrv_arb_rdpipe, the latency shift register plus rdata/rvalid demux, parameterised by MEM_RD_LATENCY.

Test Plan:
1. Reset, then r0 read 0x010 (RAM preloaded 0x5A) → r0_gnt same cycle; r0_rvalid=1 and r0_rdata=0x5A two cycles later; r1_rvalid stays 0.
2. r0_req and r1_req held continuously, MAX_WAIT=4 → grant pattern r0,r0,r0,r0,r1 repeating; never two gnt in one cycle.
3. r1 write 0x3C7=0xA5, next cycle r0 read 0x3C7 → r0_rdata=0xA5 two cycles after the read grant.
4. Alternating reads r0@0x001, r1@0x002, r0@0x003 on consecutive cycles → rvalid pulses alternate r0, r1, r0 on consecutive cycles with the matching data.
5. r0 read granted, reset_n pulsed low the next cycle → no rvalid afterwards; all outputs at reset values.
6. With IECDRV_ARB_STATS_EN: 3 r0 grants and 2 r1 grants → r0_count=3, r1_count=2; stats_clr together with a grant → both counters 0.

Source files
------------

// File: rtl/iecdrv_arb_pkg.sv
// iecdrv_arb_pkg
// Shared types and constants for the drive RAM arbiter.
//   req_id_t     : requester id (ID_CPU = 0, ID_LOADER = 1)
//   pipe_stage_t : one in-flight read slot {valid, id}
//   MEM_RD_LATENCY : cycles from read grant to returned data
package iecdrv_arb_pkg;

  localparam int MEM_RD_LATENCY = 2;

  typedef enum logic {
    ID_CPU    = 1'b0,
    ID_LOADER = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } pipe_stage_t;

endpackage

// File: rtl/iecdrv_arb_rdpipe.sv
// iecdrv_arb_rdpipe
// Read-latency tracker and read-data demux. Each granted read enters stage 0
// with the winner's id; when it reaches the last stage the RAM's q belongs to
// that requester.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   i_load_valid          : a read was granted this cycle
//   i_load_id             : id of the granted requester
//   i_mem_q               : RAM read data
//   o_r0_rvalid/o_r0_rdata: CPU read return
//   o_r1_rvalid/o_r1_rdata: loader read return
module iecdrv_arb_rdpipe
  import iecdrv_arb_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int LATENCY   = MEM_RD_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_load_valid,
  input  req_id_t              i_load_id,
  input  logic [DATAWIDTH-1:0] i_mem_q,
  output logic                 o_r0_rvalid,
  output logic [DATAWIDTH-1:0] o_r0_rdata,
  output logic                 o_r1_rvalid,
  output logic [DATAWIDTH-1:0] o_r1_rdata
);

  pipe_stage_t          r_stage [LATENCY];
  logic [DATAWIDTH-1:0] r_r0_rdata;
  logic [DATAWIDTH-1:0] r_r1_rdata;
  pipe_stage_t          w_tail;

  assign w_tail      = r_stage[LATENCY-1];
  assign o_r0_rvalid = w_tail.valid && (w_tail.id == ID_CPU);
  assign o_r1_rvalid = w_tail.valid && (w_tail.id == ID_LOADER);

  // While a return is valid the RAM q is passed straight through (it is the
  // RAM's own output register); otherwise the captured copy is held.
  assign o_r0_rdata = o_r0_rvalid ? i_mem_q : r_r0_rdata;
  assign o_r1_rdata = o_r1_rvalid ? i_mem_q : r_r1_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
      r_r0_rdata <= '0;
      r_r1_rdata <= '0;
    end else begin
      r_stage[0] <= '{valid: i_load_valid, id: i_load_id};
      for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
      if (o_r0_rvalid) r_r0_rdata <= i_mem_q;
      if (o_r1_rvalid) r_r1_rdata <= i_mem_q;
    end
  end

endmodule

// File: rtl/iecdrv_mem_arbiter.sv
// iecdrv_mem_arbiter
// Shares one port of the drive's dual-port RAM between the drive CPU (r0,
// priority) and the track/image loader (r1). A wait counter forces a loader
// grant after MAX_WAIT consecutive denied cycles so r1 is never starved.
// Handshake: rN_req is held with its we/addr/wdata until rN_gnt is seen high
// in the same cycle; that cycle the access is on the RAM port and accepted.
// Reads return rN_rvalid (one-cycle pulse) with rN_rdata two cycles later.
// Ports:
//   clk, reset_n                      : clock, async active-low reset
//   rN_req/we/addr/wdata, rN_gnt      : requester access (N = 0 CPU, 1 loader)
//   rN_rvalid/rN_rdata                : read return
//   mem_addr/mem_data/mem_wren, mem_q : RAM port
// Optional (IECDRV_ARB_STATS_EN): r0_count, r1_count grant counters and
// stats_clr synchronous clear.
module iecdrv_mem_arbiter
  import iecdrv_arb_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 11,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 r0_req,
  input  logic                 r0_we,
  input  logic [ADDRWIDTH-1:0] r0_addr,
  input  logic [DATAWIDTH-1:0] r0_wdata,
  output logic                 r0_gnt,
  output logic                 r0_rvalid,
  output logic [DATAWIDTH-1:0] r0_rdata,
  input  logic                 r1_req,
  input  logic                 r1_we,
  input  logic [ADDRWIDTH-1:0] r1_addr,
  input  logic [DATAWIDTH-1:0] r1_wdata,
  output logic                 r1_gnt,
  output logic                 r1_rvalid,
  output logic [DATAWIDTH-1:0] r1_rdata,
`ifdef IECDRV_ARB_STATS_EN
  input  logic                 stats_clr,
  output logic [15:0]          r0_count,
  output logic [15:0]          r1_count,
`endif
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_data,
  output logic                 mem_wren,
  input  logic [DATAWIDTH-1:0] mem_q
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [ADDRWIDTH-1:0] r_addr_hold;
  logic [DATAWIDTH-1:0] r_data_hold;

  logic                 w_r0_win;
  logic                 w_r1_win;
  logic                 w_any_gnt;
  logic                 w_sel_we;
  logic [ADDRWIDTH-1:0] w_sel_addr;
  logic [DATAWIDTH-1:0] w_sel_data;
  req_id_t              w_win_id;

  assign w_r1_win  = r1_req && (!r0_req || (r_wait_cnt == WAIT_MAX));
  assign w_r0_win  = r0_req && !w_r1_win;
  assign w_any_gnt = w_r0_win || w_r1_win;
  assign r0_gnt    = w_r0_win;
  assign r1_gnt    = w_r1_win;

  assign w_win_id   = w_r1_win ? ID_LOADER : ID_CPU;
  assign w_sel_we   = w_r1_win ? r1_we    : r0_we;
  assign w_sel_addr = w_r1_win ? r1_addr  : r0_addr;
  assign w_sel_data = w_r1_win ? r1_wdata : r0_wdata;

  // The RAM registers its address itself, so the port is driven in the grant
  // cycle; the hold registers only keep the bus quiet between accesses.
  assign mem_addr = w_any_gnt ? w_sel_addr : r_addr_hold;
  assign mem_data = w_any_gnt ? w_sel_data : r_data_hold;
  assign mem_wren = w_any_gnt && w_sel_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt  <= '0;
      r_addr_hold <= '0;
      r_data_hold <= '0;
    end else begin
      if (!r1_req || w_r1_win) r_wait_cnt <= '0;
      else if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_any_gnt) begin
        r_addr_hold <= w_sel_addr;
        r_data_hold <= w_sel_data;
      end
    end
  end

  iecdrv_arb_rdpipe #(
    .DATAWIDTH (DATAWIDTH),
    .LATENCY   (MEM_RD_LATENCY)
  ) u_rdpipe (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_load_valid (w_any_gnt && !w_sel_we),
    .i_load_id    (w_win_id),
    .i_mem_q      (mem_q),
    .o_r0_rvalid  (r0_rvalid),
    .o_r0_rdata   (r0_rdata),
    .o_r1_rvalid  (r1_rvalid),
    .o_r1_rdata   (r1_rdata)
  );

`ifdef IECDRV_ARB_STATS_EN
  logic [15:0] r_r0_count;
  logic [15:0] r_r1_count;

  assign r0_count = r_r0_count;
  assign r1_count = r_r1_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_r0_count <= '0;
      r_r1_count <= '0;
    end else if (stats_clr) begin
      r_r0_count <= '0;
      r_r1_count <= '0;
    end else begin
      if (w_r0_win && (r_r0_count != 16'hFFFF)) r_r0_count <= r_r0_count + 16'd1;
      if (w_r1_win && (r_r1_count != 16'hFFFF)) r_r1_count <= r_r1_count + 16'd1;
    end
  end
`endif

endmodule
